// File: rtl/popcnt_pkg.sv
// Shared definitions for the 12-bit popcount block family: widths, FSM states,
// and helpers that map a popcount k to its first and last k-bit words.
package popcnt_pkg;

  localparam int PC_W    = 12;
  localparam int PC_OH_W = 13;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  // Lowest word with k ones: (1<<k)-1, built 13 bits wide so k=12 works.
  function automatic logic [PC_W-1:0] first_word(input logic [3:0] k);
    logic [PC_W:0] ones;
    ones = (13'd1 << k) - 13'd1;
    return ones[PC_W-1:0];
  endfunction

  // Highest word with k ones: the k ones packed against the MSB.
  function automatic logic [PC_W-1:0] last_word(input logic [3:0] k);
    return first_word(k) << (4'd12 - k);
  endfunction

  function automatic logic [3:0] oh_to_k(input logic [PC_OH_W-1:0] oh);
    logic [3:0] k;
    k = 4'd0;
    for (int i = 0; i < PC_OH_W; i++) begin
      if (oh[i]) k = 4'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/gosper_next12.sv
// Next higher 12-bit word with the same popcount (Gosper's hack), with the
// divide by the lowest set bit replaced by a right shift of ctz(cur).
module gosper_next12
  import popcnt_pkg::*;
(
  input  logic [PC_W-1:0] cur,
  output logic [PC_W-1:0] nxt
);

  logic [PC_W-1:0] low_bit;
  logic [PC_W:0]   sum;
  logic [PC_W:0]   tail;
  logic [PC_W:0]   merged;
  logic [3:0]      ctz;
  logic            unused_msb;

  always_comb begin
    low_bit = cur & (~cur + 12'd1);
    sum     = {1'b0, cur} + {1'b0, low_bit};
    ctz     = 4'd12;
    for (int i = PC_W - 1; i >= 0; i--) begin
      if (cur[i]) ctz = 4'(i);
    end
    tail    = ((sum ^ {1'b0, cur}) >> 2) >> ctz;
    merged  = sum | tail;
  end

  // The top word is never advanced, so the carry out of sum is never needed.
  assign nxt        = merged[PC_W-1:0];
  assign unused_msb = merged[PC_W];

endmodule

// File: rtl/popcnt12.sv
// 12-bit population counter with a one-hot result: bit k set means k ones.
module popcnt12
  import popcnt_pkg::*;
(
  input  logic [PC_W-1:0]    data,
  output logic [PC_OH_W-1:0] cnt
);

  logic [3:0] sum;

  always_comb begin
    sum = 4'd0;
    for (int i = 0; i < PC_W; i++) begin
      sum = sum + {3'd0, data[i]};
    end
    cnt = 13'd1 << sum;
  end

endmodule

// File: rtl/popcnt12_gen.sv
// Streams every 12-bit word with k ones in ascending order for a one-hot k.
// Optional output self-check against popcnt12 when POPCNT12_GEN_CHECK_EN is defined.
module popcnt12_gen
  import popcnt_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [PC_OH_W-1:0] cmd_cnt,
  output logic               cmd_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               chk_err
);

  // Both interfaces use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds its payload until then.

  state_t             state, state_nxt;
  logic [PC_W-1:0]    data_q;
  logic [PC_W-1:0]    data_succ;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         k_q;
  logic               cmd_err_q;
  logic               is_onehot;
  logic               load;
  logic               advance;
  logic               last;

  assign is_onehot = (cmd_cnt != '0) && ((cmd_cnt & (cmd_cnt - 13'd1)) == '0);
  assign last      = (state == RUN) && (data_q == last_word(k_q));

  gosper_next12 u_next (
    .cur (data_q),
    .nxt (data_succ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && is_onehot) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last) state_nxt = IDLE;
          else      advance   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      idx_q     <= '0;
      k_q       <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= cmd_ready && cmd_valid && !is_onehot;
      if (load) begin
        data_q <= first_word(oh_to_k(cmd_cnt));
        idx_q  <= '0;
        k_q    <= oh_to_k(cmd_cnt);
      end else if (advance) begin
        data_q <= data_succ;
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  assign cmd_err  = cmd_err_q;
  assign out_data = data_q;
  assign out_idx  = idx_q;
  assign out_last = last;

`ifdef POPCNT12_GEN_CHECK_EN
  logic [PC_OH_W-1:0] chk_cnt;
  logic [PC_OH_W-1:0] cnt_q;
  logic               chk_err_q;

  popcnt12 u_chk (
    .data (data_q),
    .cnt  (chk_cnt)
  );

  // Sticky: once a streamed word disagrees with the command, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (load) cnt_q <= cmd_cnt;
      if (out_valid && out_ready && (chk_cnt != cnt_q)) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_popcnt12_gen.sv
// Directed bench for popcnt12_gen: degenerate counts, k=2/k=6 sequences,
// bad commands, back-to-back commands and reset mid-sequence.
module tb_popcnt12_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_cnt;
  logic        cmd_err;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [9:0]  out_idx;
  logic        out_last;
  logic        chk_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  popcnt12_gen #(.IDX_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_cnt   (cmd_cnt),
    .cmd_err   (cmd_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pop12(input logic [11:0] w);
    int c = 0;
    for (int i = 0; i < 12; i++) c += int'(w[i]);
    return c;
  endfunction

  task automatic check_reset_values();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cmd_err",   cmd_err,   0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_idx",   out_idx,   0);
    check("rst_out_last",  out_last,  0);
    check("rst_chk_err",   chk_err,   0);
  endtask

  // Issue one command for k and drain the stream; expected words come from
  // an ascending scan of all 4096 words, first/final/count are hand values.
  task automatic run_cmd(input int k, input bit rnd, input int exp_n,
                         input logic [11:0] exp_first, input logic [11:0] exp_final);
    int          n = 0;
    int          budget = 0;
    bit          done = 0;
    bit          rdy;
    bit          lst;
    logic [11:0] first_w = '0;
    logic [11:0] last_w = '0;
    exp_q.delete();
    for (int w = 0; w < 4096; w++) begin
      if (pop12(12'(w)) == k) exp_q.push_back(12'(w));
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_cnt   = 13'd1 << k;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_cnt   = '0;
    while (!done && budget < 5000) begin
      budget++;
      if (exp_q.size() == 0) begin
        check("extra_word", 1, 0);
        break;
      end
      check("out_valid_run", out_valid, 1);
      check("out_data", out_data, exp_q[0]);
      check("out_idx", out_idx, n);
      check("out_last", out_last, exp_q.size() == 1);
      if (n == 0) first_w = out_data;
      last_w    = out_data;
      lst       = out_last;
      rdy       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        n++;
        if (lst) done = 1;
      end
    end
    out_ready = 1'b0;
    if (!done) check("run_timeout", 0, 1);
    check("word_count",   n,         exp_n);
    check("first_word",   first_w,   exp_first);
    check("final_word",   last_w,    exp_final);
    check("bubble_valid", out_valid, 0);
    check("bubble_ready", cmd_ready, 1);
    check("chk_err_run",  chk_err,   0);
  endtask

  task automatic err_cmd(input logic [12:0] c);
    check("err_ready_pre", cmd_ready, 1);
    cmd_cnt   = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_cnt   = '0;
    check("err_pulse",     cmd_err,   1);
    check("err_valid",     out_valid, 0);
    check("err_ready",     cmd_ready, 1);
    @(negedge clk);
    check("err_pulse_end", cmd_err,   0);
    check("err_valid_end", out_valid, 0);
  endtask

  task automatic reset_mid_run();
    int budget = 0;
    cmd_cnt   = 13'h040;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_cnt   = '0;
    while (out_idx != 10'd100 && budget < 500) begin
      budget++;
      @(negedge clk);
    end
    check("mid_idx_reached", out_idx, 100);
    check("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_valid", out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_cnt   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();

    run_cmd(2,  0, 66,  12'h003, 12'hC00);
    run_cmd(0,  0, 1,   12'h000, 12'h000);
    run_cmd(12, 0, 1,   12'hFFF, 12'hFFF);
    err_cmd(13'h006);
    err_cmd(13'h000);
    run_cmd(6,  1, 924, 12'h03F, 12'hFC0);
    run_cmd(1,  0, 12,  12'h001, 12'h800);
    run_cmd(11, 0, 12,  12'h7FF, 12'hFFE);
    reset_mid_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
